// File: rtl/gpu_pkg.sv
// Shared 2D GPU definitions: opcode field map, endpoint type, shape codes
// and the splitter FSM state encoding.
package gpu_pkg;

  localparam int unsigned OP_W      = 76;
  localparam int unsigned LOC_HI    = 75;
  localparam int unsigned LOC_LO    = 38;
  localparam int unsigned COLOR_HI  = 37;
  localparam int unsigned COLOR_LO  = 22;
  localparam int unsigned SHAPE_HI  = 21;
  localparam int unsigned SHAPE_LO  = 18;
  localparam int unsigned VALID_BIT = 17;

  // One endpoint in 640x480 space
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } point_t;

  typedef enum logic [3:0] {
    SHAPE_LINE   = 4'h0,
    SHAPE_RECT   = 4'h1,
    SHAPE_CIRCLE = 4'h2,
    SHAPE_TRI    = 4'h3
  } shape_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } splitter_state_e;

endpackage

// File: rtl/point_sorter.sv
// Combinational endpoint ordering: emits the pair so that x0<x1, or
// x0==x1 with y0<=y1. Used by splitter when SPLITTER_SORT_EN is defined.
module point_sorter
  import gpu_pkg::*;
(
  input  point_t p0,
  input  point_t p1,
  output point_t q0,
  output point_t q1
);

  logic swap;

  // Swap when the first point lies after the second in (x, y) order
  always_comb begin
    swap = (p0.x > p1.x) || ((p0.x == p1.x) && (p0.y > p1.y));
    q0   = swap ? p1 : p0;
    q1   = swap ? p0 : p1;
  end

endmodule

// File: rtl/splitter.sv
// Shape-engine front end: claims opcodes whose shape field matches
// output_sel, registers endpoints and colour, and pops the upstream FIFO
// with a one-cycle read pulse. n_rst is asynchronous and active-high.
// Optional feature macro: SPLITTER_SORT_EN (endpoint ordering on capture).
module splitter
  import gpu_pkg::*;
#(
  parameter int unsigned LOC_W   = 38,
  parameter int unsigned COLOR_W = 16,
  parameter int unsigned SHAPE_W = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [OP_W-1:0]    opdata,
  input  logic [SHAPE_W-1:0] output_sel,
  output logic               read,
  output logic [LOC_W-1:0]   locations,
  output logic [COLOR_W-1:0] color
);

  splitter_state_e    state;
  splitter_state_e    state_next;
  logic               claim;
  logic               capture;
  point_t             p0_in;
  point_t             p1_in;
  point_t             p0_ord;
  point_t             p1_ord;
  logic [LOC_W-1:0]   loc_next;
  logic [COLOR_W-1:0] color_next;
  logic               unused_reserved;

  assign claim = opdata[VALID_BIT] && (opdata[SHAPE_HI:SHAPE_LO] == output_sel);
  assign p0_in = point_t'(opdata[LOC_HI -: 19]);
  assign p1_in = point_t'(opdata[LOC_LO +: 19]);
  assign unused_reserved = ^opdata[VALID_BIT-1:0];

`ifdef SPLITTER_SORT_EN
  point_sorter u_point_sorter (
    .p0 (p0_in),
    .p1 (p1_in),
    .q0 (p0_ord),
    .q1 (p1_ord)
  );
`else
  assign p0_ord = p0_in;
  assign p1_ord = p1_in;
`endif

  // State register
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: a claim moves to WAIT, WAIT always returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (claim) state_next = WAIT;
      WAIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: capture only from IDLE; opdata is ignored in WAIT
  always_comb begin
    capture    = (state == IDLE) && claim;
    loc_next   = {p0_ord, p1_ord};
    color_next = opdata[COLOR_HI:COLOR_LO];
  end

  // Registered outputs: read pulses once per capture, fields hold otherwise
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      read      <= 1'b0;
      locations <= '0;
      color     <= '0;
    end else begin
      read <= capture;
      if (capture) begin
        locations <= loc_next;
        color     <= color_next;
      end
    end
  end

endmodule

// File: tb/tb_splitter.sv
// Directed scoreboard bench for splitter.
module tb_splitter;

  logic        tb_clk = 1'b0;
  logic        n_rst;
  logic [75:0] opdata;
  logic [3:0]  output_sel;
  logic        read;
  logic [37:0] locations;
  logic [15:0] color;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic [37:0] locs;
    logic [15:0] col;
  } exp_t;

  exp_t        sb[$];
  logic [37:0] last_locs = '0;
  logic [15:0] last_col  = '0;

  always #5 tb_clk = ~tb_clk;

  splitter #(.LOC_W(38), .COLOR_W(16), .SHAPE_W(4)) dut (
    .clk        (tb_clk),
    .n_rst      (n_rst),
    .opdata     (opdata),
    .output_sel (output_sel),
    .read       (read),
    .locations  (locations),
    .color      (color)
  );

  function automatic logic [75:0] mk(input logic [9:0] x0, input logic [8:0] y0,
                                     input logic [9:0] x1, input logic [8:0] y1,
                                     input logic [15:0] c, input logic [3:0] shape,
                                     input logic valid);
    return {x0, y0, x1, y1, c, shape, valid, 17'h1ABCD};
  endfunction

  // Reference endpoint ordering
  function automatic logic [37:0] exp_locs(input logic [75:0] w);
    logic [9:0] ax, bx;
    logic [8:0] ay, by;
    {ax, ay, bx, by} = w[75:38];
`ifdef SPLITTER_SORT_EN
    if ((ax > bx) || ((ax == bx) && (ay > by))) return {bx, by, ax, ay};
`endif
    return {ax, ay, bx, by};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [75:0] w);
    exp_t e;
    e.locs = exp_locs(w);
    e.col  = w[37:22];
    sb.push_back(e);
  endtask

  // Advance one edge, check read, and on a pop compare captured fields
  task automatic tick(input string tag, input logic exp_read);
    exp_t e;
    @(posedge tb_clk);
    #1;
    chk({tag, "_read"}, {63'd0, read}, {63'd0, exp_read});
    if (read === 1'b1) begin
      if (sb.size() == 0) begin
        chk({tag, "_unexpected_pop"}, 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        last_locs = e.locs;
        last_col  = e.col;
      end
    end
    chk({tag, "_locs"}, {26'd0, locations}, {26'd0, last_locs});
    chk({tag, "_color"}, {48'd0, color}, {48'd0, last_col});
  endtask

  logic [75:0] w;

  initial begin
    n_rst      = 1'b1;
    output_sel = 4'h1;
    opdata     = mk(10'd3, 9'd5, 10'd100, 9'd200, 16'hF800, 4'h1, 1'b1);

    // Reset held with a claimable word present: reset wins
    repeat (3) tick("reset", 1'b0);

    @(negedge tb_clk);
    n_rst  = 1'b0;
    opdata = '0;
    tick("idle", 1'b0);

    // Basic claim
    @(negedge tb_clk);
    w = mk(10'd3, 9'd5, 10'd100, 9'd200, 16'hF800, 4'h1, 1'b1);
    opdata = w;
    push(w);
    tick("basic", 1'b1);
    chk("basic_locs_literal", {26'd0, locations},
        {26'd0, 10'd3, 9'd5, 10'd100, 9'd200});
    opdata = '0;
    tick("basic_after", 1'b0);

    // Shape mismatch, then invalid: outputs hold
    @(negedge tb_clk);
    opdata = mk(10'd7, 9'd8, 10'd9, 9'd10, 16'h001F, 4'h2, 1'b1);
    repeat (10) tick("mismatch", 1'b0);
    @(negedge tb_clk);
    opdata = mk(10'd7, 9'd8, 10'd9, 9'd10, 16'h001F, 4'h1, 1'b0);
    repeat (10) tick("invalid", 1'b0);

    // Back-to-back: next word appears while in WAIT
    @(negedge tb_clk);
    w = mk(10'd11, 9'd22, 10'd33, 9'd44, 16'h07E0, 4'h1, 1'b1);
    opdata = w;
    push(w);
    tick("b2b_a", 1'b1);
    w = mk(10'd55, 9'd66, 10'd77, 9'd88, 16'h1234, 4'h1, 1'b1);
    opdata = w;
    push(w);
    tick("b2b_wait", 1'b0);
    tick("b2b_b", 1'b1);
    opdata = '0;
    tick("b2b_end", 1'b0);

    // output_sel changing during WAIT only takes effect back in IDLE
    @(negedge tb_clk);
    output_sel = 4'h3;
    w = mk(10'd1, 9'd2, 10'd3, 9'd4, 16'hAAAA, 4'h3, 1'b1);
    opdata = w;
    push(w);
    tick("sel_a", 1'b1);
    output_sel = 4'h5;
    w = mk(10'd5, 9'd6, 10'd7, 9'd8, 16'h5555, 4'h5, 1'b1);
    opdata = w;
    push(w);
    tick("sel_wait", 1'b0);
    tick("sel_b", 1'b1);
    opdata = '0;
    tick("sel_end", 1'b0);

    // Shape code 0 with a fixed location pattern
    @(negedge tb_clk);
    output_sel = 4'h0;
    w = '0;
    w[75:38] = 38'b00000000110000001001000010000001000101;
    w[37:22] = 16'hC3C3;
    w[17]    = 1'b1;
    opdata = w;
    push(w);
    tick("shape0", 1'b1);
    chk("shape0_literal", {26'd0, locations},
        {26'd0, 38'b00000000110000001001000010000001000101});
    opdata = '0;
    tick("shape0_end", 1'b0);

    // Endpoint ordering cases
    @(negedge tb_clk);
    output_sel = 4'h2;
    w = mk(10'd500, 9'd10, 10'd20, 9'd30, 16'hBEEF, 4'h2, 1'b1);
    opdata = w;
    push(w);
    tick("sort_x", 1'b1);
    opdata = '0;
    tick("sort_x_end", 1'b0);
    @(negedge tb_clk);
    w = mk(10'd7, 9'd9, 10'd7, 9'd2, 16'h0F0F, 4'h2, 1'b1);
    opdata = w;
    push(w);
    tick("sort_y", 1'b1);
    opdata = '0;
    tick("sort_y_end", 1'b0);

    // Asynchronous reset between edges clears outputs at once
    @(negedge tb_clk);
    #2;
    n_rst = 1'b1;
    #1;
    chk("async_rst_locs", {26'd0, locations}, 64'd0);
    chk("async_rst_color", {48'd0, color}, 64'd0);
    chk("async_rst_read", {63'd0, read}, 64'd0);
    last_locs = '0;
    last_col  = '0;
    @(negedge tb_clk);
    n_rst = 1'b0;

    // Reset during WAIT drops the read pulse immediately
    @(negedge tb_clk);
    w = mk(10'd100, 9'd100, 10'd200, 9'd200, 16'hFFFF, 4'h2, 1'b1);
    opdata = w;
    push(w);
    tick("wait_rst_cap", 1'b1);
    opdata = '0;
    #2;
    n_rst = 1'b1;
    #1;
    chk("wait_rst_read", {63'd0, read}, 64'd0);
    chk("wait_rst_locs", {26'd0, locations}, 64'd0);
    last_locs = '0;
    last_col  = '0;
    @(negedge tb_clk);
    n_rst = 1'b0;
    tick("post_rst", 1'b0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/splitter.md
Name: splitter

Overview:
- Front end of one shape-rendering engine in the 2D GPU.
- Watches the shared 76-bit opcode word and claims opcodes whose shape field matches this engine's select code.
- Splits a claimed opcode into registered endpoint locations and colour.
- Pulses `read` for one cycle to pop the upstream opcode FIFO.

Parameters:
- `LOC_W`, 38: location field width; x0[9:0], y0[8:0], x1[9:0], y1[8:0] (640x480 space).
- `COLOR_W`, 16: RGB565 colour width.
- `SHAPE_W`, 4: shape / select code width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `n_rst`  in  1  asynchronous reset, active-high (asserted = 1 despite the name).
- `opdata`  in  76  opcode word at upstream FIFO head.
- `output_sel`  in  4  shape code this engine accepts; quasi-static.
- `read`  out  1  one-cycle pop/acknowledge to the upstream FIFO.
- `locations`  out  38  registered {x0,y0,x1,y1} of the last claimed opcode.
- `color`  out  16  registered colour of the last claimed opcode.

Behaviour:
- Opcode field map:
  - [75:38] locations: [75:66]=x0, [65:57]=y0, [56:47]=x1, [46:38]=y1.
  - [37:22] colour.
  - [21:18] shape.
  - [17] valid.
  - [16:0] reserved, ignored.
- Reset (`n_rst`=1, asynchronous): `locations`=0, `color`=0, `read`=0, state=IDLE. Reset mid-capture aborts with no pop.
- Claim condition: `opdata[17]`=1 AND `opdata[21:18]`==`output_sel`.
- FSM, two states:
  - IDLE, claim false: hold all outputs, `read`=0.
  - IDLE, claim true: at the clock edge, `locations`<=opdata[75:38], `color`<=opdata[37:22], `read`<=1, go to WAIT.
  - WAIT: `read`<=0, `opdata` ignored for this cycle (FIFO head updating), go to IDLE unconditionally.
- `read` is registered and high for exactly one cycle per claimed opcode; never high two consecutive cycles.
- Latency: claim visible at the edge -> outputs and `read` valid the following cycle.
- Throughput: at most one opcode per 2 cycles.
- Non-matching or invalid opcode: no capture, no `read`; outputs keep previous values indefinitely.
- Shape code 0 is a legal select value, matched like any other.
- `output_sel` changing while in WAIT has no effect until IDLE.
- Simultaneous reset and claim: reset wins.

Optional Feature:
- `SPLITTER_SORT_EN` defined: on capture, endpoints are ordered so that x0<x1, or x0==x1 with y0<=y1. If the incoming pair violates this, it is swapped before registering. Colour is unaffected. Combinational comparator only; latency unchanged.
- `SPLITTER_SORT_EN` undefined: endpoints are registered exactly as received.

Decomposition:
- Shared package `gpu_pkg`:
  - field bit positions and widths (`LOC_HI`/`LOC_LO`, `COLOR_HI`/`COLOR_LO`, `SHAPE_HI`/`SHAPE_LO`, `VALID_BIT`).
  - `point_t` struct {x[9:0], y[8:0]}.
  - shape code enum.
  - `splitter_state_e` {IDLE, WAIT}.
- One natural sub-module, `point_sorter`: combinational endpoint ordering, instantiated only under `SPLITTER_SORT_EN`.

Test Plan:
- Reset: assert `n_rst`=1 mid-run -> `locations`=0, `color`=0, `read`=0 immediately, without waiting for a clock.
- Basic claim: `output_sel`=4'h1, opdata with x0=3, y0=5, x1=100, y1=200, colour 16'hF800, shape 4'h1, valid=1 -> next cycle `locations`={10'd3,9'd5,10'd100,9'd200}, `color`=16'hF800, `read`=1 for one cycle only.
- Mismatch: same word with shape 4'h2, or valid=0 -> `read` stays 0 and outputs hold prior values for 10 cycles.
- Back-to-back: two matching words held continuously -> `read` pulses on alternate cycles (1,0,1,0); second capture overwrites the first.
- Shape 0: `output_sel`=4'h0, opdata[75:38]=38'b0000000110000001001000010000001000101 with valid set -> `locations` equals that pattern exactly.
- Sort (macro on): x0=500, y0=10, x1=20, y1=30 -> `locations`={10'd20,9'd30,10'd500,9'd10}. Macro off: order unchanged.
